eager_fork_data: RTL and testbench
==================================

// Module: eager_fork_data
// PURPOSE
//  Eager fork: distributes one input token (data + valid) to SIZE consumers, each with its own ready.
//  Counterpart of join_type on the producer side; sits after dataflow units (e.g. arith results) feeding several users.
//  Each output fires independently; the input is consumed only once every output has accepted the token.
//  Optional one-slot registered input stage breaks the combinational ins_ready path.
// PARAMETERS
//  SIZE        2   number of outputs, >= 1
//  DATA_WIDTH  32  token data width, >= 1 (payload broadcast unchanged)
//  BUFFERED    0   0: fork core driven directly by ins; 1: one-slot register in front of the core
// PORTS
//  clk         in   1                  clock, rising edge
//  rst         in   1                  reset, asynchronous, active-low
//  ins         in   DATA_WIDTH         input token data
//  ins_valid   in   1                  input token valid
//  ins_ready   out  1                  input token accepted when ins_valid & ins_ready
//  outs        out  SIZE*DATA_WIDTH    output data, slice i = outs[i*DATA_WIDTH +: DATA_WIDTH]
//  outs_valid  out  SIZE               per-output valid
//  outs_ready  in   SIZE               per-output ready
// BEHAVIOUR
//  Reset (rst=0, async): all emitted flags 0, slot empty -> outs_valid=0; ins_ready=1 if BUFFERED else equals core rule.
//  Core (src_data/src_valid = ins or slot contents):
//   - emitted[i]: register, 1 = output i already took the current token.
//   - outs_valid[i] = src_valid & ~emitted[i]; every outs slice = src_data.
//   - core_ready = &(emitted | (outs_valid & outs_ready)): all outputs done or accepting now.
//   - emitted[i] next = src_valid & ~core_ready & (emitted[i] | (outs_valid[i] & outs_ready[i])).
//   - So on core_ready all flags clear same edge; next token starts fresh.
//  BUFFERED=0: ins_ready = core_ready; latency 0 (combinational valid/data); ready depends on outs_ready.
//  BUFFERED=1: slot full/data regs; ins_ready = ~full | core_ready (no comb path from ins_valid).
//   - load on ins_valid & ins_ready; full next = (ins_valid & ins_ready) | (full & ~core_ready).
//   - latency 1 cycle ins -> outs; sustains 1 token/cycle when all outputs ready.
//  Rules: outs_valid[i] never drops without handshake; outs data stable while any outs_valid high.
//   - Output i receives each token exactly once; tokens never reorder or duplicate.
//   - Simultaneous acceptance by all outputs in one cycle: consumed that cycle, no flags set.
//   - SIZE=1 degenerates to a wire (BUFFERED=0) or one-slot buffer (BUFFERED=1).
//   - Reset mid-token: token in flight dropped, flags/slot cleared, no output handshake completes during reset.
//  No combinational path from outs_ready to outs_valid.
// STRUCTURE
//  Package: none needed; widths are parameters only.
//  Sub-module: eager_fork_register_block (one per output: emitted flag, outs_valid[i], per-output ready term).
//  Top: optional slot (generate on BUFFERED), AND-reduce of block ready terms, data broadcast.
// TESTING
//  1. SIZE=3, BUFFERED=0, all ready, ins=0xA5 valid -> outs_valid=3'b111 all slices 0xA5, ins_ready=1 same cycle.
//  2. SIZE=3, outs_ready=3'b001 then 3'b010 then 3'b100 -> outs_valid 111,110,100; ins_ready=1 only 3rd cycle; each output fires once.
//  3. SIZE=2, BUFFERED=1, stream 0x01..0x10 back-to-back, all ready -> outputs show same sequence 1 cycle later, 1 token/cycle, ins_ready held 1.
//  4. BUFFERED=1, outs_ready=0 for 4 cycles with ins_valid=1 -> one token held, ins_ready=0 after load, data stable, no loss.
//  5. rst pulsed low mid-token (emitted=2'b01) -> outs_valid=0 immediately, next token delivered to both outputs.
//  6. Random ready/valid per output over 10k tokens vs scoreboard -> each output sequence equals input sequence, no stalls beyond need.

Source files
------------

// File: rtl/eager_fork_register_block.sv
// Per-output tracking for the eager fork: remembers whether this output already
// took the current token and produces its share of the core ready term.
module eager_fork_register_block (
   input  logic clk,
   input  logic rst,
   input  logic src_valid,
   input  logic out_ready,
   input  logic core_ready,
   output logic out_valid,
   output logic ready_term
);

   logic emitted_q, emitted_d;

   always_comb begin
      out_valid  = src_valid & ~emitted_q;
      ready_term = emitted_q | (out_valid & out_ready);
      // Flags clear on the edge the whole fork consumes the token.
      emitted_d  = src_valid & ~core_ready & ready_term;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         emitted_q <= 1'b0;
      end else begin
         emitted_q <= emitted_d;
      end
   end

endmodule

// File: rtl/eager_fork_data.sv
// Eager fork: broadcasts one input token to SIZE consumers, each firing independently;
// the input is consumed once every consumer has taken it. Optional one-slot input register.
module eager_fork_data #(
   parameter int unsigned SIZE       = 2,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BUFFERED   = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_WIDTH-1:0]        ins,
   input  logic                         ins_valid,
   output logic                         ins_ready,
   output logic [SIZE*DATA_WIDTH-1:0]   outs,
   output logic [SIZE-1:0]              outs_valid,
   input  logic [SIZE-1:0]              outs_ready
);

   logic                  src_valid;
   logic [DATA_WIDTH-1:0] src_data;
   logic                  core_ready;
   logic [SIZE-1:0]       ready_terms;

   generate
      if (BUFFERED != 0) begin : g_slot
         logic                  full_q, full_d;
         logic [DATA_WIDTH-1:0] data_q, data_d;
         logic                  load;

         always_comb begin
            load   = ins_valid & ins_ready;
            full_d = load | (full_q & ~core_ready);
            data_d = load ? ins : data_q;
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               full_q <= 1'b0;
               data_q <= '0;
            end else begin
               full_q <= full_d;
               data_q <= data_d;
            end
         end

         assign src_valid = full_q;
         assign src_data  = data_q;
         assign ins_ready = ~full_q | core_ready;
      end else begin : g_direct
         // Gate with reset so no output handshake can complete while reset is held.
         assign src_valid = ins_valid & rst;
         assign src_data  = ins;
         assign ins_ready = core_ready;
      end
   endgenerate

   assign core_ready = &ready_terms;

   for (genvar i = 0; i < SIZE; i++) begin : g_out
      eager_fork_register_block u_block (
         .clk        (clk),
         .rst        (rst),
         .src_valid  (src_valid),
         .out_ready  (outs_ready[i]),
         .core_ready (core_ready),
         .out_valid  (outs_valid[i]),
         .ready_term (ready_terms[i])
      );
      assign outs[i*DATA_WIDTH +: DATA_WIDTH] = src_data;
   end

endmodule

// File: tb/tb_eager_fork_data.sv
// Bench for eager_fork_data: an unbuffered SIZE=3 instance and a buffered SIZE=2 instance,
// checked every cycle against a token-count model plus directed literal checks.
module tb_eager_fork_data;

   localparam int NA   = 3;
   localparam int WA   = 8;
   localparam int NB   = 2;
   localparam int WB   = 32;
   localparam int NTOK = 16384;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [WA-1:0]    ins_a;
   logic             ins_valid_a, ins_ready_a;
   logic [NA*WA-1:0] outs_a;
   logic [NA-1:0]    outs_valid_a, outs_ready_a;

   logic [WB-1:0]    ins_b;
   logic             ins_valid_b, ins_ready_b;
   logic [NB*WB-1:0] outs_b;
   logic [NB-1:0]    outs_valid_b, outs_ready_b;

   eager_fork_data #(.SIZE(NA), .DATA_WIDTH(WA), .BUFFERED(0)) dut_a (
      .clk(clk), .rst(rst), .ins(ins_a), .ins_valid(ins_valid_a), .ins_ready(ins_ready_a),
      .outs(outs_a), .outs_valid(outs_valid_a), .outs_ready(outs_ready_a)
   );

   eager_fork_data #(.SIZE(NB), .DATA_WIDTH(WB), .BUFFERED(1)) dut_b (
      .clk(clk), .rst(rst), .ins(ins_b), .ins_valid(ins_valid_b), .ins_ready(ins_ready_b),
      .outs(outs_b), .outs_valid(outs_valid_b), .outs_ready(outs_ready_b)
   );

   int total = 0;
   int bad   = 0;

   // Model: token k of a stream is gen[k]; tok = tokens accepted at the input,
   // cnt[i] = tokens handed to output i.
   logic [WA-1:0] gen_a [NTOK];
   logic [WB-1:0] gen_b [NTOK];
   int   tok_a = 0, tok_b = 0;
   int   cnt_a [NA];
   int   cnt_b [NB];
   logic hold_a = 1'b0, hold_b = 1'b0;
   logic [NA-1:0] ev_a;
   logic [NB-1:0] ev_b;
   logic er_a, er_b;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : compare
      if (!rst) begin
         check("rst_a_valid", 32'(outs_valid_a), 32'd0);
         check("rst_a_ready", 32'(ins_ready_a), 32'd0);
         check("rst_b_valid", 32'(outs_valid_b), 32'd0);
         check("rst_b_ready", 32'(ins_ready_b), 32'd1);
         // Token in flight is dropped; the producer moves on to a fresh one.
         tok_a = tok_a + 1;
         for (int i = 0; i < NA; i++) cnt_a[i] = tok_a;
         for (int i = 0; i < NB; i++) cnt_b[i] = tok_b;
         hold_a = 1'b0;
         hold_b = 1'b0;
      end else begin
         er_a = 1'b1;
         for (int i = 0; i < NA; i++) begin
            ev_a[i] = ins_valid_a && (cnt_a[i] == tok_a);
            if (!((cnt_a[i] > tok_a) || (ev_a[i] && outs_ready_a[i]))) er_a = 1'b0;
         end
         er_b = 1'b1;
         for (int i = 0; i < NB; i++) begin
            ev_b[i] = cnt_b[i] < tok_b;
            if (!((cnt_b[i] == tok_b) || (ev_b[i] && outs_ready_b[i]))) er_b = 1'b0;
         end
         if (ev_b == '0) er_b = 1'b1;

         check("a_valid", 32'(outs_valid_a), 32'(ev_a));
         check("a_ready", 32'(ins_ready_a), 32'(er_a));
         check("b_valid", 32'(outs_valid_b), 32'(ev_b));
         check("b_ready", 32'(ins_ready_b), 32'(er_b));
         for (int i = 0; i < NA; i++)
            if (ev_a[i]) check("a_data", 32'(outs_a[i*WA +: WA]), 32'(gen_a[tok_a % NTOK]));
         for (int i = 0; i < NB; i++)
            if (ev_b[i]) check("b_data", outs_b[i*WB +: WB], gen_b[(tok_b - 1) % NTOK]);

         for (int i = 0; i < NA; i++) if (ev_a[i] && outs_ready_a[i]) cnt_a[i]++;
         for (int i = 0; i < NB; i++) if (ev_b[i] && outs_ready_b[i]) cnt_b[i]++;
         if (ins_valid_a && er_a) tok_a++;
         if (ins_valid_b && er_b) tok_b++;
         hold_a = ins_valid_a && !er_a;
         hold_b = ins_valid_b && !er_b;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [WA-1:0] d, input logic [NA-1:0] r);
      gen_a[tok_a % NTOK] = d;
      ins_a = d;
      ins_valid_a = v;
      outs_ready_a = r;
   endtask

   task automatic drive_b(input logic v, input logic [WB-1:0] d, input logic [NB-1:0] r);
      gen_b[tok_b % NTOK] = d;
      ins_b = d;
      ins_valid_b = v;
      outs_ready_b = r;
   endtask

   initial begin
      for (int i = 0; i < NTOK; i++) begin
         gen_a[i] = WA'($urandom);
         gen_b[i] = $urandom;
      end
      for (int i = 0; i < NA; i++) cnt_a[i] = 0;
      for (int i = 0; i < NB; i++) cnt_b[i] = 0;
      rst = 1'b0;
      ins_a = '0; ins_valid_a = 1'b0; outs_ready_a = '0;
      ins_b = '0; ins_valid_b = 1'b0; outs_ready_b = '0;
      repeat (2) step();
      rst = 1'b1;

      // All outputs ready: token broadcast and consumed in the same cycle.
      drive_a(1'b1, 8'hA5, 3'b111);
      @(negedge clk);
      check("t1_valid", 32'(outs_valid_a), 32'h7);
      check("t1_ready", 32'(ins_ready_a), 32'h1);
      check("t1_data", 32'(outs_a), 32'hA5A5A5);

      // One output per cycle.
      step(); drive_a(1'b1, 8'h3C, 3'b001);
      @(negedge clk);
      check("t2_valid0", 32'(outs_valid_a), 32'h7);
      check("t2_ready0", 32'(ins_ready_a), 32'h0);
      step(); outs_ready_a = 3'b010;
      @(negedge clk);
      check("t2_valid1", 32'(outs_valid_a), 32'h6);
      check("t2_ready1", 32'(ins_ready_a), 32'h0);
      step(); outs_ready_a = 3'b100;
      @(negedge clk);
      check("t2_valid2", 32'(outs_valid_a), 32'h4);
      check("t2_ready2", 32'(ins_ready_a), 32'h1);
      check("t2_data", 32'(outs_a[2*WA +: WA]), 32'h3C);
      step(); drive_a(1'b0, 8'h00, 3'b000);

      // Reset in the middle of a partially delivered token.
      step(); drive_a(1'b1, 8'h5A, 3'b001);
      @(negedge clk);
      check("t5_pre", 32'(outs_valid_a), 32'h7);
      step(); rst = 1'b0;
      @(negedge clk);
      check("t5_rst", 32'(outs_valid_a), 32'h0);
      step(); rst = 1'b1; drive_a(1'b1, 8'h77, 3'b111);
      @(negedge clk);
      check("t5_after_valid", 32'(outs_valid_a), 32'h7);
      check("t5_after_data", 32'(outs_a), 32'h777777);
      step(); drive_a(1'b0, 8'h00, 3'b000);

      // Buffered streaming: 0x01..0x10 back to back, one cycle of latency.
      for (int k = 1; k <= 16; k++) begin
         if (k > 1) step();
         drive_b(1'b1, 32'(k), 2'b11);
         @(negedge clk);
         check("t3_ready", 32'(ins_ready_b), 32'h1);
         if (k > 1) begin
            check("t3_valid", 32'(outs_valid_b), 32'h3);
            check("t3_data", outs_b[WB +: WB], 32'(k - 1));
         end
      end
      step(); drive_b(1'b0, 32'h0, 2'b11);
      @(negedge clk);
      check("t3_last", outs_b[31:0], 32'h10);

      // Buffered stall: one token held while outputs are blocked.
      step(); drive_b(1'b1, 32'hDEAD_BEEF, 2'b00);
      @(negedge clk);
      check("t4_load_ready", 32'(ins_ready_b), 32'h1);
      for (int c = 0; c < 3; c++) begin
         step(); drive_b(1'b1, 32'h0BAD_F00D, 2'b00);
         @(negedge clk);
         check("t4_stall_ready", 32'(ins_ready_b), 32'h0);
         check("t4_stall_valid", 32'(outs_valid_b), 32'h3);
         check("t4_stall_data", outs_b[WB +: WB], 32'hDEAD_BEEF);
      end
      step(); outs_ready_b = 2'b11;
      @(negedge clk);
      check("t4_release", 32'(ins_ready_b), 32'h1);
      step(); drive_b(1'b0, 32'h0, 2'b11);
      @(negedge clk);
      check("t4_next", outs_b[31:0], 32'h0BAD_F00D);
      step(); outs_ready_b = 2'b00;

      // Randomized traffic; producers hold valid until accepted.
      for (int c = 0; c < 40000; c++) begin
         step();
         if (!hold_a) ins_valid_a = ($urandom_range(0, 9) < 7);
         ins_a = gen_a[tok_a % NTOK];
         for (int i = 0; i < NA; i++) outs_ready_a[i] = ($urandom_range(0, 3) != 0);
         if (!hold_b) ins_valid_b = ($urandom_range(0, 9) < 7);
         ins_b = gen_b[tok_b % NTOK];
         for (int i = 0; i < NB; i++) outs_ready_b[i] = ($urandom_range(0, 3) != 0);
      end
      step();
      ins_valid_a = 1'b0; ins_valid_b = 1'b0;
      @(negedge clk);
      check("a_token_volume", 32'(tok_a > 10000), 32'h1);
      check("b_token_volume", 32'(tok_b > 10000), 32'h1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
